// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan capture block: segment patterns,
// FSM state type and digit-enable helpers.
package seg7_pkg;

   // Active-low segment patterns {a,b,c,d,e,f,g}
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;

   // Exactly one enable low selects a digit; blanking and ghosting are rejected
   function automatic logic an_onehot(input logic [3:0] an_n);
      return $onehot(~an_n);
   endfunction

   function automatic logic [1:0] an_index(input logic [3:0] an_n);
      logic [1:0] idx;
      idx = 2'd0;
      for (int k = 3; k >= 0; k--)
         if (!an_n[k]) idx = 2'(k);
      return idx;
   endfunction

endpackage

// File: rtl/seg7_to_bin.sv
// Combinational 7-segment pattern to hex nibble decoder; unknown patterns
// (including blank) return 0 with err set.
module seg7_to_bin
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] nib,
   output logic       err
);

   always_comb begin
      nib = 4'h0;
      err = 1'b0;
      case (seg_n)
         SEG_0:   nib = 4'h0;
         SEG_1:   nib = 4'h1;
         SEG_2:   nib = 4'h2;
         SEG_3:   nib = 4'h3;
         SEG_4:   nib = 4'h4;
         SEG_5:   nib = 4'h5;
         SEG_6:   nib = 4'h6;
         SEG_7:   nib = 4'h7;
         SEG_8:   nib = 4'h8;
         SEG_9:   nib = 4'h9;
         SEG_A:   nib = 4'hA;
         SEG_B:   nib = 4'hB;
         SEG_C:   nib = 4'hC;
         SEG_D:   nib = 4'hD;
         SEG_E:   nib = 4'hE;
         SEG_F:   nib = 4'hF;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 4-digit 7-segment display bus, captures each digit
// once it has been stable, and pulses frame_valid when all four are seen.
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_n,
   input  logic [3:0]  an_n,
   output logic [15:0] value,
   output logic [3:0]  digit_err,
   output logic        frame_valid,
   output logic        frame_err
);

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   // {seg,an} bundled through the synchronizer and the one-cycle history copy
   logic [10:0] sync1, sync2, prev;
   logic [6:0]  s_seg;
   logic [3:0]  s_an;
   logic        an_ok, change;
   logic [1:0]  dig;
   logic [3:0]  sel, mask, mask_upd, err_upd;
   logic [15:0] value_upd;
   logic [3:0]  nib;
   logic        nib_err;
   logic [7:0]  cnt;
   state_t      state;

   assign s_seg  = sync2[10:4];
   assign s_an   = sync2[3:0];
   assign an_ok  = an_onehot(s_an);
   assign change = (sync2 != prev) || !an_ok;
   assign dig    = an_index(s_an);
   assign sel    = 4'b0001 << dig;

   seg7_to_bin u_dec (
      .seg_n (s_seg),
      .nib   (nib),
      .err   (nib_err)
   );

   always_comb begin
      value_upd = value;
      value_upd[{dig, 2'b00} +: 4] = nib;
      err_upd = digit_err;
      err_upd[dig] = nib_err;
      mask_upd = mask | sel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
         prev  <= '1;
      end else begin
         sync1 <= {seg_n, an_n};
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_WAIT;
         cnt         <= 8'd0;
         mask        <= 4'd0;
         value       <= 16'd0;
         digit_err   <= 4'd0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            S_WAIT: begin
               cnt <= 8'd0;
               if (!change) state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (change) begin
                  cnt   <= 8'd0;
                  state <= an_ok ? S_SETTLE : S_WAIT;
               end else if (cnt == CNT_LAST) begin
                  state     <= S_HOLD;
                  value     <= value_upd;
                  digit_err <= err_upd;
                  // Completing the frame clears the mask on this same edge
                  if (mask_upd == 4'hF) begin
                     mask        <= 4'd0;
                     frame_valid <= 1'b1;
                     frame_err   <= |err_upd;
                  end else begin
                     mask <= mask_upd;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_HOLD: begin
               if (change) begin
                  cnt   <= 8'd0;
                  state <= an_ok ? S_SETTLE : S_WAIT;
               end
            end
            default: state <= S_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed self-checking bench for seg7_scan_capture (STABLE_CYCLES = 4).
module tb_seg7_scan_capture;
   import seg7_pkg::*;

   logic        clk;
   logic        rst;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic [15:0] value;
   logic [3:0]  digit_err;
   logic        frame_valid;
   logic        frame_err;

   int n_cmp  = 0;
   int n_fail = 0;
   int fv_cnt = 0;
   int ferr_stray = 0;
   logic last_ferr = 1'b0;

   seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .value       (value),
      .digit_err   (digit_err),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (frame_valid) begin
         fv_cnt    <= fv_cnt + 1;
         last_ferr <= frame_err;
      end else if (frame_err) begin
         ferr_stray <= ferr_stray + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      an_n  = 4'hF;
      seg_n = SEG_BLANK;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
      logic [6:0] pats [4];
      pats[0] = p0; pats[1] = p1; pats[2] = p2; pats[3] = p3;
      for (int k = 0; k < 4; k++) begin
         an_n  = ~(4'b0001 << k);
         seg_n = pats[k];
         repeat (10) tick();
      end
      an_n = 4'hF;
      repeat (5) tick();
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      an_n  = 4'hF;
      seg_n = SEG_BLANK;
      #1;
      repeat (3) tick();
      n_cmp++; if (value !== 16'h0) begin n_fail++; $display("FAIL reset_value got %h exp 0000", value); end
      n_cmp++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL reset_err got %b exp 0000", digit_err); end
      n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b exp 0", frame_valid); end
      n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_latency();
      do_reset();
      an_n  = 4'b1110;
      seg_n = SEG_2;
      repeat (7) tick();
      n_cmp++; if (value !== 16'h0) begin n_fail++; $display("FAIL lat_early got %h exp 0000", value); end
      tick();
      n_cmp++; if (value[3:0] !== 4'h2) begin n_fail++; $display("FAIL lat_value got %h exp 2", value[3:0]); end
      n_cmp++; if (digit_err[0] !== 1'b0) begin n_fail++; $display("FAIL lat_err got %b exp 0", digit_err[0]); end
   endtask

   task automatic test_scan();
      int start;
      do_reset();
      start = fv_cnt;
      scan(SEG_1, SEG_A, SEG_D, SEG_F);
      n_cmp++; if (value !== 16'hFDA1) begin n_fail++; $display("FAIL scan_value got %h exp fda1", value); end
      n_cmp++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL scan_err got %b exp 0000", digit_err); end
      n_cmp++; if (fv_cnt - start !== 1) begin n_fail++; $display("FAIL scan_pulses got %0d exp 1", fv_cnt - start); end
      n_cmp++; if (last_ferr !== 1'b0) begin n_fail++; $display("FAIL scan_ferr got %b exp 0", last_ferr); end
   endtask

   task automatic test_blank();
      int start;
      do_reset();
      start = fv_cnt;
      scan(SEG_1, SEG_A, SEG_BLANK, SEG_F);
      n_cmp++; if (value !== 16'hF0A1) begin n_fail++; $display("FAIL blank_value got %h exp f0a1", value); end
      n_cmp++; if (digit_err !== 4'b0100) begin n_fail++; $display("FAIL blank_err got %b exp 0100", digit_err); end
      n_cmp++; if (fv_cnt - start !== 1) begin n_fail++; $display("FAIL blank_pulses got %0d exp 1", fv_cnt - start); end
      n_cmp++; if (last_ferr !== 1'b1) begin n_fail++; $display("FAIL blank_ferr got %b exp 1", last_ferr); end
   endtask

   task automatic test_unstable();
      int start;
      start = fv_cnt;
      an_n = 4'b1110;
      for (int i = 0; i < 10; i++) begin
         seg_n = (i % 2 == 0) ? SEG_8 : SEG_0;
         repeat (3) tick();
      end
      an_n = 4'hF;
      repeat (5) tick();
      n_cmp++; if (value !== 16'hF0A1) begin n_fail++; $display("FAIL unstable_value got %h exp f0a1", value); end
      n_cmp++; if (fv_cnt - start !== 0) begin n_fail++; $display("FAIL unstable_pulses got %0d exp 0", fv_cnt - start); end
   endtask

   task automatic test_multi_an();
      an_n  = 4'b1100;
      seg_n = SEG_8;
      repeat (20) tick();
      n_cmp++; if (value !== 16'hF0A1) begin n_fail++; $display("FAIL multi_an_value got %h exp f0a1", value); end
      an_n = 4'b1101;
      repeat (10) tick();
      n_cmp++; if (value[7:4] !== 4'h8) begin n_fail++; $display("FAIL multi_an_nib got %h exp 8", value[7:4]); end
      n_cmp++; if (value !== 16'hF081) begin n_fail++; $display("FAIL multi_an_full got %h exp f081", value); end
      an_n = 4'hF;
      repeat (5) tick();
   endtask

   task automatic test_reset_mid();
      int start;
      do_reset();
      start = fv_cnt;
      an_n = 4'b1110; seg_n = SEG_3; repeat (10) tick();
      an_n = 4'b1101; seg_n = SEG_4; repeat (10) tick();
      an_n = 4'b1011; seg_n = SEG_5; repeat (10) tick();
      n_cmp++; if (value !== 16'h0543) begin n_fail++; $display("FAIL pre_rst_value got %h exp 0543", value); end
      an_n = 4'b0111; seg_n = SEG_7;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      n_cmp++; if (value !== 16'h0) begin n_fail++; $display("FAIL mid_rst_value got %h exp 0000", value); end
      n_cmp++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL mid_rst_err got %b exp 0000", digit_err); end
      n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fv got %b exp 0", frame_valid); end
      n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ferr got %b exp 0", frame_err); end
      repeat (2) tick();
      rst = 1'b0;
      repeat (12) tick();
      n_cmp++; if (value !== 16'h7000) begin n_fail++; $display("FAIL post_rst_value got %h exp 7000", value); end
      n_cmp++; if (fv_cnt - start !== 0) begin n_fail++; $display("FAIL post_rst_pulses got %0d exp 0", fv_cnt - start); end
      an_n = 4'hF;
      repeat (3) tick();
   endtask

   initial begin
      rst   = 1'b1;
      an_n  = 4'hF;
      seg_n = SEG_BLANK;
      test_reset();
      test_latency();
      test_scan();
      test_blank();
      test_unstable();
      test_multi_an();
      test_reset_mid();
      n_cmp++; if (ferr_stray !== 0) begin n_fail++; $display("FAIL ferr_without_fv got %0d exp 0", ferr_stray); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_capture.md
SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive unchanged synchronized samples required before a digit is captured (legal range 2..255).
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 seg_n  input  7  segment lines {a,b,c,d,e,f,g}, active-low (0 = lit), asynchronous to clk.
REQ-005 an_n  input  4  digit enables, active-low; bit k low selects digit k; asynchronous to clk.
REQ-006 value  output  16  captured hex digits; nibble k = value[4k+3:4k].
REQ-007 digit_err  output  4  bit k set when the last capture of digit k held an undecodable pattern.
REQ-008 frame_valid  output  1  one-cycle pulse when all four digits have been captured since the previous pulse.
REQ-009 frame_err  output  1  valid with frame_valid: OR of digit_err at pulse time; 0 otherwise.

Function
REQ-010 seg_n and an_n SHALL each pass through a 2-flop synchronizer; s_seg/s_an denote stage-2 outputs, p_seg/p_an their one-cycle-delayed copies.
REQ-011 Decode table (seg_n -> nibble): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->b, 0110001->C, 1000010->d, 0110000->E, 0111000->F.
REQ-012 Any other pattern, including blank 1111111, SHALL decode as nibble 0 with error flag 1.
REQ-013 an_n is "valid" when exactly one bit is low; all-high (blanking) or multiple lows are invalid.
REQ-014 "Change" = (s_seg,s_an) != (p_seg,p_an) or s_an invalid.
REQ-015 FSM states WAIT, SETTLE, HOLD; 8-bit stability counter cnt.
REQ-016 WAIT: cnt=0; go SETTLE when s_an valid and no change.
REQ-017 SETTLE: on change -> cnt=0 (stay SETTLE if s_an valid, else WAIT); else cnt++; when cnt==STABLE_CYCLES-1 with no change, capture and go HOLD.
REQ-018 HOLD: no further capture; on change -> cnt=0 and SETTLE (s_an valid) or WAIT (invalid).
REQ-019 Capture of digit k SHALL write nibble k of value and digit_err[k] at the capture edge and set captured-mask bit k; other nibbles unchanged.
REQ-020 Latency: a single pin-level change held steady SHALL update value exactly STABLE_CYCLES+3 clk edges after the first edge sampling it.
REQ-021 Recapture of a digit already in the mask SHALL overwrite its nibble/err; the mask is unchanged.
REQ-022 When a capture makes the mask 1111, frame_valid and frame_err SHALL assert on the following cycle for one cycle, and the mask SHALL clear on that same capture edge.
REQ-023 A capture coinciding with the frame_valid cycle SHALL count toward the next frame.
REQ-024 value and digit_err persist between captures; they do not clear at frame_valid.

Reset
REQ-025 rst SHALL force: value=0, digit_err=0, frame_valid=0, frame_err=0, mask=0, cnt=0, state WAIT, all synchronizer and p_* flops to 1 (inactive).
REQ-026 rst asserted mid-SETTLE SHALL abandon the pending capture; no frame_valid after release until four new captures.

Structure
REQ-027 Package seg7_pkg SHALL hold the 16 pattern constants, SEG_BLANK, and the FSM state typedef.
REQ-028 Sub-module seg7_to_bin (combinational: 7-bit pattern -> 4-bit nibble + err) SHALL implement REQ-011/012.

Verification
REQ-029 Reset, then drive an_n=1110, seg_n=0010010 steady -> value[3:0]=2, digit_err[0]=0 exactly 7 edges later (STABLE_CYCLES=4).
REQ-030 Scan digits 0..3 with patterns 1,A,d,F, 10 cycles each -> value=16'hFDA1, one frame_valid pulse, frame_err=0.
REQ-031 Same scan, digit 2 blank 1111111 -> value=16'hF0A1, digit_err=4'b0100, frame_err=1 with frame_valid.
REQ-032 Toggle seg_n every 3 cycles on digit 0 -> no capture; value unchanged; no frame_valid.
REQ-033 an_n=1100 held 20 cycles -> no capture; then an_n=1101 with seg_n=0000000 -> value[7:4]=8.
REQ-034 Assert rst after three digits captured, release, capture one digit -> no frame_valid; all outputs 0 during reset.
